// File: rtl/pipe_cla_subtractor.sv
// rtl/pipe_cla_subtractor.sv - two-stage pipelined carry-lookahead subtractor with valid/ready flow control
// Optional feature macro: SUB_SATURATE_EN (clamp Diff to 0 when A < B).
module pipe_cla_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Zero
);

    localparam int H = WIDTH / 2;

    // Half-width lookahead adder: returns {carry_out, sum}.
    function automatic logic [H:0] cla_half(input logic [H-1:0] a,
                                            input logic [H-1:0] b,
                                            input logic         cin);
        logic [H-1:0] g;
        logic [H-1:0] p;
        logic [H:0]   c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < H; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[H], p ^ c[H-1:0]};
    endfunction

    // Stage-1 registers
    logic         s1_v_q;
    logic [H-1:0] s1_diff_lo_q;
    logic         s1_carry_q;
    logic [H-1:0] s1_a_hi_q;
    logic [H-1:0] s1_nb_hi_q;

    // Stage-2 (output) registers
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    // Next-state values
    logic [H:0]       lo_sum_d;
    logic [H:0]       hi_sum_d;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_d;
    logic             zero_d;

    logic s2_adv;
    logic s1_adv;

    // A stage moves when its downstream slot is empty or being drained.
    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_v_q | s2_adv;
    assign in_ready = s1_adv & ~rst;

    // Low half of A + ~B + 1 in stage 1, upper half chained off the stored carry in stage 2.
    always_comb begin
        lo_sum_d = cla_half(A[H-1:0], ~B[H-1:0], 1'b1);
        hi_sum_d = cla_half(s1_a_hi_q, s1_nb_hi_q, s1_carry_q);
        borrow_d = ~hi_sum_d[H];
        zero_d   = ({hi_sum_d[H-1:0], s1_diff_lo_q} == '0);
`ifdef SUB_SATURATE_EN
        diff_d   = borrow_d ? '0 : {hi_sum_d[H-1:0], s1_diff_lo_q};
`else
        diff_d   = {hi_sum_d[H-1:0], s1_diff_lo_q};
`endif
    end

    // Stage 1: capture low-half result and the upper operand halves on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q       <= 1'b0;
            s1_diff_lo_q <= '0;
            s1_carry_q   <= 1'b0;
            s1_a_hi_q    <= '0;
            s1_nb_hi_q   <= '0;
        end else if (s1_adv) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_diff_lo_q <= lo_sum_d[H-1:0];
                s1_carry_q   <= lo_sum_d[H];
                s1_a_hi_q    <= A[WIDTH-1:H];
                s1_nb_hi_q   <= ~B[WIDTH-1:H];
            end
        end
    end

    // Stage 2: register the full result; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_v_q;
            if (s1_v_q) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Diff      = diff_q;
    assign Borrow    = borrow_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_subtractor.sv
// tb/tb_pipe_cla_subtractor.sv - directed self-checking bench for pipe_cla_subtractor
module tb_pipe_cla_subtractor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Diff;
    logic        Borrow;
    logic        Zero;

    int tests;
    int failed;

    pipe_cla_subtractor #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Borrow    (Borrow),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        borrow;
        logic        zero;
    } vec_t;

    vec_t vecs [8];

    // Wrapped difference adjusted for the clamping build.
    function automatic logic [31:0] exp_diff(input logic [31:0] d, input logic brw);
`ifdef SUB_SATURATE_EN
        return brw ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        @(negedge clk);
        in_valid  = 1'b1;
        A         = vecs[idx].a;
        B         = vecs[idx].b;
        out_ready = 1'b1;
        #1 chk($sformatf("v%0d_in_ready", idx), {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        #1 chk($sformatf("v%0d_early_valid", idx), {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_out_valid", idx), {31'b0, out_valid}, 32'd1);
        chk($sformatf("v%0d_diff", idx), Diff, exp_diff(vecs[idx].diff, vecs[idx].borrow));
        chk($sformatf("v%0d_borrow", idx), {31'b0, Borrow}, {31'b0, vecs[idx].borrow});
        chk($sformatf("v%0d_zero", idx), {31'b0, Zero}, {31'b0, vecs[idx].zero});
    endtask

    logic [31:0] sa [8];
    logic [31:0] sb [8];

    initial begin
        int sent;
        int recv;
        int ready_low;
        int cyc;
        logic        prev_stall;
        logic [31:0] prev_diff;
        logic        prev_borrow;
        logic        prev_zero;
        logic [31:0] wd;

        tests    = 0;
        failed   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        out_ready = 1'b1;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};

        // Reset state
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_diff", Diff, 32'd0);
        chk("rst_borrow_zero", {30'b0, Borrow, Zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // Stream 8 pairs with the consumer stalled on cycles 3..6.
        for (int k = 0; k < 8; k++) begin
            sa[k] = 32'h0000_1000 * (k + 1) + k;
            sb[k] = 32'h0000_3000 + 32'h10 * k;
        end
        @(negedge clk);
        sent        = 0;
        recv        = 0;
        ready_low   = 0;
        prev_stall  = 1'b0;
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_zero   = 1'b0;
        for (cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            A         = (sent < 8) ? sa[sent] : 32'hDEAD_BEEF;
            B         = (sent < 8) ? sb[sent] : 32'h0BAD_F00D;
            #1;
            if (!in_ready) ready_low++;
            if (prev_stall) begin
                chk($sformatf("stall_c%0d_valid", cyc), {31'b0, out_valid}, 32'd1);
                chk($sformatf("stall_c%0d_diff", cyc), Diff, prev_diff);
                chk($sformatf("stall_c%0d_flags", cyc), {30'b0, Borrow, Zero},
                    {30'b0, prev_borrow, prev_zero});
            end
            if (out_valid && out_ready) begin
                wd = sa[recv] - sb[recv];
                chk($sformatf("stream_r%0d_diff", recv), Diff,
                    exp_diff(wd, sa[recv] < sb[recv]));
                chk($sformatf("stream_r%0d_borrow", recv), {31'b0, Borrow},
                    {31'b0, sa[recv] < sb[recv]});
                recv++;
            end
            prev_stall  = out_valid && !out_ready;
            prev_diff   = Diff;
            prev_borrow = Borrow;
            prev_zero   = Zero;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        chk("stream_received", recv, 32'd8);
        chk("stream_sent", sent, 32'd8);
        chk("stream_ready_low_cycles", ready_low, 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset with two results in flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 32'h0000_0009;
        B = 32'h0000_0002;
        @(negedge clk);
        A = 32'h0000_0007;
        B = 32'h0000_0001;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("inflight_valid", {31'b0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_diff", Diff, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 chk($sformatf("no_stale_c%0d", c), {31'b0, out_valid}, 32'd0);
        end

        // First transaction after reset, wrap-around case.
        run_vec(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
